// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the UART instruction-memory loader.
// Imported by the receiver, the loader top and the testbench.
package imem_loader_pkg;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 8 * LEN_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Debug view of both FSMs.
  typedef struct packed {
    loader_state_t loader;
    rx_state_t     rx;
  } dbg_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port. The loader drives it as master; imem is the slave.
// Handshake: a word is written on every cycle where we=1; there is no backpressure.
interface imem_uart_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           wdata;

  modport master (output we, output waddr, output wdata);
  modport slave  (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/imem_uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-filtered start bit.
// Emits a one-cycle start_o on a confirmed start bit, then byte_valid_o or frame_err_o.
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_i,
  output logic [7:0] byte_o,
  output logic      byte_valid_o,
  output logic      frame_err_o,
  output logic      start_o,
  output rx_state_t state_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_q, state_d;
  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             start_q, start_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RX_IDLE;
      sync_q       <= 2'b11;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], rx_i};
      prev_q       <= rx_s;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      start_q      <= start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    start_d      = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          // A line that is high again at mid-start was only a glitch.
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            start_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d        = '0;
          state_d      = RX_IDLE;
          byte_valid_d = rx_s;
          frame_err_d  = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign start_o      = start_q;
  assign state_o      = state_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a length-prefixed, XOR-checked program image from UART into imem and
// keeps the core in reset until the image is complete and verified.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  imem_uart_loader_if.master  imem,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output dbg_t                dbg_o
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_WIDTH;

  logic      [7:0] rx_byte;
  logic            rx_valid, rx_ferr, rx_start;
  rx_state_t       rx_state;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr),
    .start_o      (rx_start),
    .state_o      (rx_state)
  );

  loader_state_t         state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      word_cnt_q, word_cnt_d;
  logic [31:0]           data_q, data_d;
  logic [7:0]            chk_q, chk_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [LEN_W-1:0]      len_new;
  logic                  terminal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      byte_idx_q <= '0;
      wr_pend_q  <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      data_q     <= data_d;
      chk_q      <= chk_d;
      byte_idx_q <= byte_idx_d;
      wr_pend_q  <= wr_pend_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign len_new  = {rx_byte, len_q[7:0]};
  assign terminal = (state_q == ST_DONE) || (state_q == ST_ERROR);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    data_d     = data_q;
    chk_d      = chk_q;
    byte_idx_d = byte_idx_q;
    wr_pend_d  = 1'b0;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    // A completed word is written one cycle after its last byte; the word
    // counter is wider than waddr so the final address never wraps.
    if (wr_pend_q) begin
      we_d       = 1'b1;
      waddr_d    = word_cnt_q[ADDR_WIDTH-1:0];
      wdata_d    = data_q;
      word_cnt_d = word_cnt_q + 1'b1;
    end

    if (rx_ferr && !terminal) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_IDLE:   if (rx_start) state_d = ST_LEN_LO;
        ST_LEN_LO: begin
          if (rx_valid) begin
            len_d   = {len_q[LEN_W-1:8], rx_byte};
            state_d = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            len_d = len_new;
            if ({1'b0, len_new} > CAPACITY) state_d = ST_ERROR;
            else if (len_new == '0)         state_d = ST_CHECK;
            else                            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            data_d     = {rx_byte, data_q[31:8]};
            chk_d      = chk_q ^ rx_byte;
            byte_idx_d = byte_idx_q + 1'b1;
            if (byte_idx_q == 2'(WORD_BYTES - 1)) begin
              wr_pend_d = 1'b1;
              if (word_cnt_q + 1'b1 == len_q) state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (rx_valid) state_d = (rx_byte == chk_q) ? ST_DONE : ST_ERROR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign imem.we    = we_q;
  assign imem.waddr = waddr_q;
  assign imem.wdata = wdata_q;
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERROR);
  assign cpu_hold   = !done;
  assign busy       = !(state_q == ST_IDLE || done || err);
  assign dbg_o      = '{loader: state_q, rx: rx_state};

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader at 10 clocks/bit and a 16-word imem.
// Writes are checked against an expected queue; status flags at end of each frame.
module tb_imem_uart_loader;
  import imem_loader_pkg::*;

  localparam int AW  = 4;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic cpu_hold, busy, done, err;
  dbg_t dbg;

  imem_uart_loader_if #(.ADDR_WIDTH(AW)) imem ();

  imem_uart_loader #(
    .CLK_FREQ   (1000000),
    .BAUD       (100000),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .imem     (imem),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dbg_o    (dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int writes_seen = 0;
  logic [AW+31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe is matched against the expected queue.
  always @(negedge clk) begin
    if (imem.we === 1'b1) begin
      writes_seen++;
      if (exp_q.size() > 0) check("write", {imem.waddr, imem.wdata}, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
    writes_seen = 0;
    exp_q.delete();
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      tick(1);
      n++;
    end
    if (!(done || err)) check("end_timeout", 64'(done || err), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_we"},       imem.we, 0);
    check({tag, "_waddr"},    imem.waddr, 0);
    check({tag, "_wdata"},    imem.wdata, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_err"},      err, 0);
    check({tag, "_state"},    dbg.loader, ST_IDLE);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input int nwr);
    tick(3);
    @(negedge clk);
    check({tag, "_done"},     done, d);
    check({tag, "_err"},      err, e);
    check({tag, "_cpu_hold"}, cpu_hold, !d);
    check({tag, "_writes"},   writes_seen, nwr);
  endtask

  task automatic send_small_image(input logic [7:0] chk);
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    exp_q.push_back({4'd0, 32'h0000_0013});
    exp_q.push_back({4'd1, 32'h0010_0093});
    foreach (img[i]) send_byte(img[i], 1'b1);
    send_byte(chk, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    tick(4);
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(5);

    // Good load: checksum is XOR of the eight data bytes, 13^93^10 = 0x90.
    send_small_image(8'h90);
    wait_end(2000);
    check_status("load", 1'b1, 1'b0, 2);
    check("load_last_waddr", imem.waddr, 4'd1);

    pulse_reset();
    send_small_image(8'h81);
    wait_end(2000);
    check_status("badchk", 1'b0, 1'b1, 2);

    pulse_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_end(2000);
    check_status("zero", 1'b1, 1'b0, 0);

    pulse_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    @(negedge clk);
    check("oversize_err_after_len", err, 1);
    check("oversize_busy", busy, 0);
    check_status("oversize", 1'b0, 1'b1, 0);

    // Full capacity: words 0..15, whose bytes XOR to 0x00.
    pulse_reset();
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int w = 0; w < 16; w++) begin
      exp_q.push_back({4'(w), 32'(w)});
      send_byte(8'(w), 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
    end
    send_byte(8'h00, 1'b1);
    wait_end(2000);
    check_status("full", 1'b1, 1'b0, 16);
    check("full_last_waddr", imem.waddr, 4'hF);
    check("full_last_wdata", imem.wdata, 32'h0000_000F);

    // Later activity after DONE is ignored.
    send_byte(8'h55, 1'b0);
    check_status("after_done", 1'b1, 1'b0, 16);

    pulse_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b0);
    wait_end(2000);
    check_status("stop0", 1'b0, 1'b1, 0);

    pulse_reset();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(4 * CPB);
    check_reset_outputs("glitch");
    check("glitch_rx_state", dbg.rx, RX_IDLE);

    pulse_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    @(negedge clk);
    check("middata_state", dbg.loader, ST_DATA);
    check("middata_busy", busy, 1);
    reset = 1'b0;
    tick(2);
    check_reset_outputs("middata_reset");
    reset = 1'b1;
    tick(3);
    writes_seen = 0;
    send_small_image(8'h90);
    wait_end(2000);
    check_status("reload", 1'b1, 1'b0, 2);
    check("reload_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
